pixel_stream_aligner: RTL
=========================

PIXEL_STREAM_ALIGNER -- requirements
Module: pixel_stream_aligner

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the RGB pixel width (8 bits per component).
REQ-002 SHALL have parameter BLANK_COLOR, default 24'h000000, meaning the pixel value driven whenever no valid pixel is available.
REQ-003 SHALL have port pixel_clk  input  1  the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port s_tdata  input  DATA_W  framebuffer pixel beat.
REQ-006 SHALL have port s_tvalid  input  1  beat valid.
REQ-007 SHALL have port s_tready  output  1  beat accepted when s_tvalid && s_tready.
REQ-008 SHALL have port s_tuser  input  1  start-of-frame (first pixel of frame).
REQ-009 SHALL have port s_tlast  input  1  end-of-line (last pixel of line).
REQ-010 SHALL have port hsync_in  input  1  timing hsync, active low.
REQ-011 SHALL have port vsync_in  input  1  timing vsync, active low.
REQ-012 SHALL have port de_in  input  1  timing data enable, active high.
REQ-013 SHALL have ports hsync_out, vsync_out, de_out  output  1 each  timing delayed by one cycle.
REQ-014 SHALL have port rgb_out  output  DATA_W  pixel aligned to de_out.
REQ-015 SHALL have port locked  output  1  high while in STREAM.
REQ-016 SHALL have port err_pulse  output  1  one-cycle pulse per error event.
REQ-017 SHALL have port err_count  output  16  saturating error counter.

Function
REQ-018 SHALL register hsync_in, vsync_in and de_in into the *_out outputs with a fixed latency of exactly one cycle.
REQ-019 SHALL keep an internal sof_pending flag: set on any cycle with vsync_in==0, cleared on any cycle with de_in==1; frame_start = de_in && sof_pending.
REQ-020 SHALL implement FSM states SEEK, WAIT_FRAME and STREAM.
REQ-021 In SEEK, SHALL drive s_tready = !s_tuser, discarding non-SOF beats; on s_tvalid && s_tuser, SHALL go to WAIT_FRAME without consuming the beat.
REQ-022 In WAIT_FRAME, SHALL drive s_tready = frame_start; on frame_start, SHALL consume the held SOF beat, output it, and go to STREAM.
REQ-023 In STREAM, SHALL drive s_tready = de_in; each de_in cycle SHALL consume exactly one beat.
REQ-024 SHALL register rgb_out as s_tdata when a beat is consumed in WAIT_FRAME/STREAM, and as BLANK_COLOR otherwise, including all cycles where de_in==0 and all cycles in SEEK.
REQ-025 In STREAM, SHALL flag an underflow error when de_in==1 && s_tvalid==0, and SHALL output BLANK_COLOR for that pixel.
REQ-026 In STREAM, SHALL flag an SOF error when a consumed beat has s_tuser != frame_start.
REQ-027 In STREAM, SHALL flag an EOL error on a de_in falling edge (de_in==0, previous de_in==1) when the last consumed beat had s_tlast==0.
REQ-028 In STREAM, SHALL flag an EOL error when a consumed beat has s_tlast==1 while the next cycle still has de_in==1.
REQ-029 On any error, SHALL go to SEEK on the next cycle, pulse err_pulse for one cycle, and increment err_count by 1.
REQ-030 Multiple errors in the same cycle SHALL count once; err_count SHALL saturate at 16'hFFFF.
REQ-031 SHALL register locked as (next state == STREAM).
REQ-032 In SEEK and WAIT_FRAME, de_in activity SHALL NOT generate errors; de_out SHALL still follow de_in and rgb_out SHALL be BLANK_COLOR.
REQ-033 s_tready SHALL be a combinational function of state, s_tuser, de_in and sof_pending only, never of s_tvalid.

Reset
REQ-034 While rst==1, SHALL force state=SEEK, sof_pending=0, s_tready=0, hsync_out=1, vsync_out=1, de_out=0, rgb_out=BLANK_COLOR, locked=0, err_pulse=0 and err_count=0.
REQ-035 Reset asserted mid-line or mid-frame SHALL take effect on the next pixel_clk edge; after release, the block SHALL resync only via SEEK.

Verification
REQ-036 Nominal: 4x2 active frame; stream SOF beat 0x000001 with 8 beats and tlast on beats 4 and 8 -> locked rises on the first active pixel; rgb_out = 1..8 one cycle after each de_in; err_count = 0.
REQ-037 Late stream: s_tvalid=0 for the whole first frame, then valid -> SEEK/WAIT_FRAME outputs BLANK; lock at the second frame_start; no errors.
REQ-038 Underflow: drop s_tvalid for one active pixel in line 1 -> that pixel outputs BLANK; err_pulse=1 once; err_count=1; locked=0; relocks next frame.
REQ-039 Short line: tlast on beat 3 of a 4-pixel line -> EOL error; err_count=1; garbage beats discarded until next SOF; relock next frame.
REQ-040 Saturation and reset: force 65537 errors -> err_count = 16'hFFFF; then rst=1 for one cycle mid-frame -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/pixel_stream_aligner.sv
// -----------------------------------------------------------------------------
// pixel_stream_aligner
//
// Aligns a framebuffer AXI-Stream pixel source to a free-running video timing
// generator. The timing (hsync/vsync/de) is the master; the stream is pulled
// one beat per active pixel once the block has locked onto a start-of-frame.
//
// State table
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   SEEK         | discard non-SOF beats until an SOF beat is at the head
//   WAIT_FRAME   | hold the SOF beat until the timing reaches its first pixel
//   STREAM       | locked; one beat consumed per de_in cycle, errors checked
//
// Ports
//   pixel_clk            in   sole clock, rising edge
//   rst                  in   synchronous, active-high reset
//   s_tdata/valid/ready  AXI-Stream pixel beat handshake
//   s_tuser              in   start-of-frame marker on the first beat
//   s_tlast              in   end-of-line marker on the last beat of a line
//   hsync_in/vsync_in    in   timing syncs, active low
//   de_in                in   timing data enable, active high
//   hsync_out/vsync_out/de_out  out  timing delayed by one cycle
//   rgb_out              out  pixel aligned with de_out
//   locked               out  high while the block is in STREAM
//   err_pulse            out  one-cycle pulse per error event
//   err_count            out  saturating count of error events
// -----------------------------------------------------------------------------
module pixel_stream_aligner #(
    parameter int                 DATA_W      = 24,
    parameter logic [DATA_W-1:0]  BLANK_COLOR = {DATA_W{1'b0}}
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              de_in,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out,
    output logic [DATA_W-1:0] rgb_out,
    output logic              locked,
    output logic              err_pulse,
    output logic [15:0]       err_count
);

    typedef enum logic [1:0] {
        ST_SEEK       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_STREAM     = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_sof_pending;
    logic                r_de_d;
    logic                r_cons_d;
    logic                r_last_tlast;

    logic                r_hsync;
    logic                r_vsync;
    logic                r_de;
    logic [DATA_W-1:0]   r_rgb;
    logic                r_locked;
    logic                r_err_pulse;
    logic [15:0]         r_err_count;

    logic                w_frame_start;
    logic                w_ready;
    logic                w_consume;
    logic                w_err_underflow;
    logic                w_err_sof;
    logic                w_err_eol_fall;
    logic                w_err_eol_early;
    logic                w_err;

    assign w_frame_start = de_in && r_sof_pending;

    // Next state, handshake and error detection.
    always_comb begin
        w_state_nxt     = r_state;
        w_ready         = 1'b0;
        w_consume       = 1'b0;
        w_err_underflow = 1'b0;
        w_err_sof       = 1'b0;
        w_err_eol_fall  = 1'b0;
        w_err_eol_early = 1'b0;
        w_err           = 1'b0;

        case (r_state)
            ST_SEEK: begin
                // Keep an SOF beat at the head; everything else is dropped.
                w_ready = !s_tuser;
                if (s_tvalid && s_tuser) begin
                    w_state_nxt = ST_WAIT_FRAME;
                end
            end

            ST_WAIT_FRAME: begin
                w_ready = w_frame_start;
                if (w_frame_start) begin
                    if (s_tvalid) begin
                        w_consume   = 1'b1;
                        w_state_nxt = ST_STREAM;
                    end else begin
                        // The held SOF beat disappeared; start over quietly.
                        w_state_nxt = ST_SEEK;
                    end
                end
            end

            ST_STREAM: begin
                w_ready = de_in;
                if (de_in) begin
                    if (s_tvalid) begin
                        w_consume = 1'b1;
                        w_err_sof = (s_tuser != w_frame_start);
                    end else begin
                        w_err_underflow = 1'b1;
                    end
                end
                // Line ended without the stream marking it as ended.
                w_err_eol_fall  = !de_in && r_de_d && !r_last_tlast;
                // Stream ended the line while the timing is still active.
                w_err_eol_early = de_in && r_cons_d && r_last_tlast;
                w_err = w_err_underflow || w_err_sof || w_err_eol_fall || w_err_eol_early;
                if (w_err) begin
                    w_state_nxt = ST_SEEK;
                end
            end

            default: begin
                w_state_nxt = ST_SEEK;
            end
        endcase

        // Nothing is accepted while reset is held.
        if (rst) begin
            w_ready   = 1'b0;
            w_consume = 1'b0;
        end
    end

    assign s_tready = w_ready;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state       <= ST_SEEK;
            r_sof_pending <= 1'b0;
            r_de_d        <= 1'b0;
            r_cons_d      <= 1'b0;
            r_last_tlast  <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_rgb         <= BLANK_COLOR;
            r_locked      <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_err_count   <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;

            // The first active pixel closes the pending window even if
            // vsync is still low on that same cycle.
            if (de_in) begin
                r_sof_pending <= 1'b0;
            end else if (!vsync_in) begin
                r_sof_pending <= 1'b1;
            end

            r_de_d   <= de_in;
            r_cons_d <= w_consume;
            if (w_consume) begin
                r_last_tlast <= s_tlast;
            end

            r_hsync <= hsync_in;
            r_vsync <= vsync_in;
            r_de    <= de_in;
            r_rgb   <= w_consume ? s_tdata : BLANK_COLOR;

            r_locked    <= (w_state_nxt == ST_STREAM);
            r_err_pulse <= w_err;
            if (w_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign hsync_out = r_hsync;
    assign vsync_out = r_vsync;
    assign de_out    = r_de;
    assign rgb_out   = r_rgb;
    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule
